// File: rtl/ldpc_encode.sv
// ldpc_encode: systematic QC-LDPC encoder; info bytes in, info echo then parity bytes out.
// Define LDPC_ENC_PARITY_ONLY_EN to suppress the info echo and emit only the parity bytes.
module ldpc_encode #(
    parameter int Z  = 256,
    parameter int KB = 32,
    parameter int MB = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  en_din,
    input  logic [7:0]            d_in,
    output logic                  din_rdy,
    output logic [7:0]            d_out,
    output logic                  en_out,
    output logic                  f_out,
    output logic                  busy,
    output logic [$clog2(KB)-1:0] rom_addr,
    input  logic [MB*Z-1:0]       rom_data
);
    // state | meaning
    // IDLE  | waiting for start
    // FETCH | greg <= generator first rows of column rom_addr
    // LOAD  | din_rdy high, waiting for the next info byte
    // BITS  | 8 cycles folding the shift byte into parity, MSB first
    // PAR   | emitting parity bytes, block 0 first, MSB first

    localparam int PW     = MB * Z;
    localparam int BPB    = Z / 8;
    localparam int PBYTES = PW / 8;
    localparam int AW     = $clog2(KB);
    localparam int BW     = (BPB > 1) ? $clog2(BPB) : 1;
    localparam int PCW    = (PBYTES > 1) ? $clog2(PBYTES) : 1;

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, BITS, PAR} state_t;
    state_t state;

    logic [PW-1:0]  greg, parity, greg_rot, par_chain, chain_sh, par_shift;
    logic [7:0]     sreg;
    logic [2:0]     bit_cnt;
    logic [BW-1:0]  byte_left;
    logic [AW-1:0]  cols_left;
    logic [PCW-1:0] par_left;

    // par_chain views parity with block 0 on top so a left shift by 8 walks the output order.
    always_comb begin
        greg_rot  = '0;
        par_chain = '0;
        par_shift = '0;
        for (int m = 0; m < MB; m++) begin
            greg_rot[m*Z +: Z]         = {greg[m*Z], greg[m*Z+1 +: Z-1]};
            par_chain[(MB-1-m)*Z +: Z] = parity[m*Z +: Z];
        end
        chain_sh = par_chain << 8;
        for (int m = 0; m < MB; m++)
            par_shift[m*Z +: Z] = chain_sh[(MB-1-m)*Z +: Z];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            greg      <= '0;
            parity    <= '0;
            sreg      <= '0;
            bit_cnt   <= '0;
            byte_left <= '0;
            cols_left <= '0;
            par_left  <= '0;
            din_rdy   <= 1'b0;
            d_out     <= '0;
            en_out    <= 1'b0;
            f_out     <= 1'b0;
            busy      <= 1'b0;
            rom_addr  <= '0;
        end else begin
            en_out <= 1'b0;
            f_out  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start && !busy) begin
                        busy      <= 1'b1;
                        parity    <= '0;
                        rom_addr  <= '0;
                        cols_left <= AW'(KB - 1);
                        state     <= FETCH;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                FETCH: begin
                    greg      <= rom_data;
                    byte_left <= BW'(BPB - 1);
                    din_rdy   <= 1'b1;
                    state     <= LOAD;
                end
                LOAD: begin
                    if (en_din) begin
                        sreg    <= d_in;
                        bit_cnt <= 3'd7;
                        din_rdy <= 1'b0;
                        state   <= BITS;
                        // next column address goes out early so the ROM has settled by FETCH
                        if (byte_left == '0 && cols_left != '0)
                            rom_addr <= rom_addr + AW'(1);
`ifndef LDPC_ENC_PARITY_ONLY_EN
                        d_out  <= d_in;
                        en_out <= 1'b1;
`endif
                    end
                end
                BITS: begin
                    if (sreg[7])
                        parity <= parity ^ greg;
                    greg    <= greg_rot;
                    sreg    <= {sreg[6:0], 1'b0};
                    bit_cnt <= bit_cnt - 3'd1;
                    if (bit_cnt == 3'd0) begin
                        if (byte_left != '0) begin
                            byte_left <= byte_left - BW'(1);
                            din_rdy   <= 1'b1;
                            state     <= LOAD;
                        end else if (cols_left != '0) begin
                            cols_left <= cols_left - AW'(1);
                            state     <= FETCH;
                        end else begin
                            par_left <= PCW'(PBYTES - 1);
                            state    <= PAR;
                        end
                    end
                end
                PAR: begin
                    d_out    <= par_chain[PW-1 -: 8];
                    en_out   <= 1'b1;
                    parity   <= par_shift;
                    par_left <= par_left - PCW'(1);
                    if (par_left == '0) begin
                        f_out    <= 1'b1;
                        rom_addr <= '0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
